seg7_scan_decoder: RTL and testbench

//  Monitors a multiplexed 7-segment display bus (segment lines + digit enables) and decodes it back to hex digits.

---
 rtl/seg7_scan_decoder.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - decodes a multiplexed 7-segment bus back to hex digits
// A pattern must be stable for STABLE_CYCLES synced samples before it is accepted.
module seg7_scan_decoder #(
  parameter int N_DIGITS         = 4,
  parameter int STABLE_CYCLES    = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [N_DIGITS-1:0]     an_in,
  input  logic                    clr_err,
  output logic [4*N_DIGITS-1:0]   hex_out,
  output logic [N_DIGITS-1:0]     digit_valid,
  output logic [N_DIGITS-1:0]     digit_blank,
  output logic [N_DIGITS-1:0]     illegal,
  output logic                    update
);

  localparam int                   CW       = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]        CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [6:0]           SEG_IDLE = 7'h7F;
  localparam logic [N_DIGITS-1:0]  AN_IDLE  = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  // Returns {legal, value}; segments are active-low, bit0=a .. bit6=g.
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  logic [6:0]            seg_s1_q, seg_s2_q, seg_prev_q;
  logic [N_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d;
  logic [N_DIGITS-1:0]   illegal_q, illegal_d;
  logic                  update_q, update_d;

  logic [N_DIGITS-1:0]   sel;
  logic                  stable;
  logic                  one_hot;
  logic                  accept;
  logic [4:0]            glyph;

  always_comb begin
    sel     = (ANODE_ACTIVE_LOW != 0) ? ~an_s2_q : an_s2_q;
    stable  = (seg_s2_q == seg_prev_q) && (an_s2_q == an_prev_q);
    one_hot = (sel != '0) && ((sel & (sel - N_DIGITS'(1))) == '0);
    accept  = stable && (cnt_q == CNT_MAX) && !done_q && one_hot;
    glyph   = glyph_decode(seg_s2_q);

    cnt_d     = cnt_q;
    done_d    = done_q;
    hex_d     = hex_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    illegal_d = clr_err ? '0 : illegal_q;

    if (!stable) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (accept) begin
      done_d = 1'b1;
    end

    // sel is one-hot whenever accept is set, so at most one digit is written.
    for (int i = 0; i < N_DIGITS; i++) begin
      if (accept && sel[i]) begin
        if (glyph[4]) begin
          hex_d[4*i +: 4] = glyph[3:0];
          valid_d[i]      = 1'b1;
          blank_d[i]      = 1'b0;
        end else if (seg_s2_q == SEG_IDLE) begin
          valid_d[i] = 1'b0;
          blank_d[i] = 1'b1;
        end else begin
          illegal_d[i] = 1'b1;
        end
      end
    end

    update_d = (hex_d != hex_q) || (valid_d != valid_q) || (blank_d != blank_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q   <= SEG_IDLE;
      seg_s2_q   <= SEG_IDLE;
      seg_prev_q <= SEG_IDLE;
      an_s1_q    <= AN_IDLE;
      an_s2_q    <= AN_IDLE;
      an_prev_q  <= AN_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      hex_q      <= '0;
      valid_q    <= '0;
      blank_q    <= '0;
      illegal_q  <= '0;
      update_q   <= 1'b0;
    end else begin
      seg_s1_q   <= seg_in;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      an_s1_q    <= an_in;
      an_s2_q    <= an_s1_q;
      an_prev_q  <= an_s2_q;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      hex_q      <= hex_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      illegal_q  <= illegal_d;
      update_q   <= update_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign illegal     = illegal_q;
  assign update      = update_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed vector bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic        clr_err = 1'b0;
  logic [15:0] hex_out;
  logic [3:0]  digit_valid, digit_blank, illegal;
  logic        update;

  int tests = 0;
  int failures = 0;
  int upd_cnt = 0;

  seg7_scan_decoder #(.N_DIGITS(4), .STABLE_CYCLES(16), .ANODE_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in), .clr_err(clr_err),
    .hex_out(hex_out), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .illegal(illegal), .update(update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update === 1'b1) upd_cnt = upd_cnt + 1;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic [3:0]  ill;
    int          upd;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    an_in  = an;
    seg_in = seg;
  endtask

  initial begin
    int base;
    int pass_pulses;
    vecs[0]  = '{4'b1110, 7'h24, 16'h0002, 4'b0001, 4'b0000, 4'b0000, 1};
    vecs[1]  = '{4'b1111, 7'h24, 16'h0002, 4'b0001, 4'b0000, 4'b0000, 0};
    vecs[2]  = '{4'b1110, 7'h24, 16'h0002, 4'b0001, 4'b0000, 4'b0000, 0};
    vecs[3]  = '{4'b1100, 7'h40, 16'h0002, 4'b0001, 4'b0000, 4'b0000, 0};
    vecs[4]  = '{4'b1101, 7'h7F, 16'h0002, 4'b0001, 4'b0010, 4'b0000, 1};
    vecs[5]  = '{4'b1101, 7'h79, 16'h0012, 4'b0011, 4'b0000, 4'b0000, 1};
    vecs[6]  = '{4'b0111, 7'h2A, 16'h0012, 4'b0011, 4'b0000, 4'b1000, 0};
    vecs[7]  = '{4'b0111, 7'h0E, 16'hF012, 4'b1011, 4'b0000, 4'b1000, 1};
    vecs[8]  = '{4'b1011, 7'h08, 16'hFA12, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[9]  = '{4'b1110, 7'h00, 16'hFA18, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[10] = '{4'b1110, 7'h03, 16'hFA1B, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[11] = '{4'b1101, 7'h46, 16'hFACB, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[12] = '{4'b1011, 7'h21, 16'hFDCB, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[13] = '{4'b0111, 7'h06, 16'hEDCB, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[14] = '{4'b1110, 7'h40, 16'hEDC0, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[15] = '{4'b1101, 7'h30, 16'hED30, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[16] = '{4'b1011, 7'h19, 16'hE430, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[17] = '{4'b0111, 7'h12, 16'h5430, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[18] = '{4'b1110, 7'h02, 16'h5436, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[19] = '{4'b1101, 7'h78, 16'h5476, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[20] = '{4'b1011, 7'h10, 16'h5976, 4'b1111, 4'b0000, 4'b1000, 1};
    vecs[21] = '{4'b1110, 7'h7F, 16'h5976, 4'b1110, 4'b0001, 4'b1000, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset hex", hex_out, 0);
    check("reset valid", digit_valid, 0);
    check("reset blank", digit_blank, 0);
    check("reset illegal", illegal, 0);
    check("reset update", update, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      base = upd_cnt;
      drive(vecs[i].an, vecs[i].seg);
      repeat (40) @(posedge clk);
      #1;
      check($sformatf("v%0d hex", i), hex_out, vecs[i].hex);
      check($sformatf("v%0d valid", i), digit_valid, vecs[i].valid);
      check($sformatf("v%0d blank", i), digit_blank, vecs[i].blank);
      check($sformatf("v%0d illegal", i), illegal, vecs[i].ill);
      check($sformatf("v%0d updates", i), upd_cnt - base, vecs[i].upd);
    end

    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("clr_err clears", illegal, 0);

    // clr_err on the very edge that accepts an illegal pattern on digit 3
    drive(4'b0111, 7'h2A);
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    check("illegal before k+18", illegal, 4'b0000);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("illegal wins over clr", illegal, 4'b1000);
    check("illegal keeps hex", hex_out, 16'h5976);
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("clr after coincident", illegal, 0);

    // exact latency: outputs move at edge k+18 only
    drive(4'b1110, 7'h24);
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    check("lat k+17 hex", hex_out, 16'h5976);
    check("lat k+17 valid", digit_valid, 4'b1110);
    check("lat k+17 update", update, 0);
    @(posedge clk); #1;
    check("lat k+18 hex", hex_out, 16'h5972);
    check("lat k+18 valid", digit_valid, 4'b1111);
    check("lat k+18 blank", digit_blank, 4'b0000);
    check("lat k+18 update", update, 1);
    @(posedge clk); #1;
    check("lat k+19 update", update, 0);
    repeat (5) @(posedge clk); #1;

    // short hold must not be accepted
    base = upd_cnt;
    drive(4'b1110, 7'h40);
    repeat (10) @(posedge clk); #1;
    drive(4'b1111, 7'h40);
    repeat (40) @(posedge clk); #1;
    check("short hold hex", hex_out, 16'h5972);
    check("short hold updates", upd_cnt - base, 0);

    // scan 0x1A3F, three passes
    for (int p = 0; p < 3; p++) begin
      base = upd_cnt;
      drive(4'b1110, 7'h0E); repeat (32) @(posedge clk); #1;
      drive(4'b1101, 7'h30); repeat (32) @(posedge clk); #1;
      drive(4'b1011, 7'h08); repeat (32) @(posedge clk); #1;
      drive(4'b0111, 7'h79); repeat (32) @(posedge clk); #1;
      pass_pulses = (p == 0) ? 4 : 0;
      check($sformatf("scan pass%0d updates", p), upd_cnt - base, pass_pulses);
    end
    check("scan hex", hex_out, 16'h1A3F);
    check("scan valid", digit_valid, 4'hF);
    check("scan blank", digit_blank, 4'h0);

    // async reset in the middle of accumulation (cnt=10)
    drive(4'b1110, 7'h40);
    @(posedge clk);
    repeat (12) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid rst hex", hex_out, 0);
    check("mid rst valid", digit_valid, 0);
    check("mid rst blank", digit_blank, 0);
    check("mid rst illegal", illegal, 0);
    check("mid rst update", update, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    check("post rst k+17 valid", digit_valid, 0);
    @(posedge clk); #1;
    check("post rst k+18 valid", digit_valid, 4'b0001);
    check("post rst k+18 hex", hex_out, 0);
    check("post rst k+18 update", update, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
